// File: rtl/lsu_ahb_dmaster_if.sv
// AHB-Lite data-side bus bundle between the load/store unit (master) and the interconnect (slave).
interface lsu_ahb_dmaster_if #(
  parameter int AW = 32
);
  logic [AW-1:0] haddr;
  logic [1:0]    htrans;
  logic          hwrite;
  logic [2:0]    hsize;
  logic [2:0]    hburst;
  logic [3:0]    hprot;
  logic [31:0]   hwdata;
  logic [31:0]   hrdata;
  logic          hready_in;
  logic          hresp;

  modport master (
    output haddr, htrans, hwrite, hsize, hburst, hprot, hwdata,
    input  hrdata, hready_in, hresp
  );

  modport slave (
    input  haddr, htrans, hwrite, hsize, hburst, hprot, hwdata,
    output hrdata, hready_in, hresp
  );
endinterface

// File: rtl/lsu_ahb_dmaster.sv
// Load/store unit AHB-Lite data master: one non-pipelined SINGLE transfer per load/store.
// Optional macro LSU_MISALIGN_TRAP_EN: trap misaligned half/word requests instead of issuing them.
module lsu_ahb_dmaster #(
  parameter int         AW        = 32,
  parameter logic [3:0] HPROT_VAL = 4'b0001
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ls_req,
  input  logic          ls_we,
  input  logic [1:0]    ls_size,
  input  logic          ls_uns,
  input  logic [AW-1:0] ls_addr,
  input  logic [31:0]   ls_wdata,
  output logic          d_hready,
  output logic [31:0]   ld_data,
  output logic          ld_valid,
  output logic          bus_err,
  output logic          misalign,
  lsu_ahb_dmaster_if.master ahb
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] addr_q, addr_n;
  logic          we_q, uns_q;
  logic [1:0]    size_q, size_n;
  logic [31:0]   wdata_q, wdata_rep;
  logic          trap, accept;
  logic [7:0]    byte_v;
  logic [15:0]   half_v;
  logic [31:0]   ld_ext;
  logic [1:0]    htrans_c;
  logic [31:0]   hwdata_c;

  // size 11 is carried as a word so hsize never advertises a 64-bit beat
  assign size_n = (ls_size == 2'b11) ? 2'b10 : ls_size;

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap   = (state == S_IDLE) && ls_req &&
                  (((size_n == 2'b01) && ls_addr[0]) ||
                   ((size_n == 2'b10) && (ls_addr[1:0] != 2'b00)));
  assign addr_n = ls_addr;
`else
  assign trap = 1'b0;
  always_comb begin
    addr_n = ls_addr;
    if (size_n == 2'b01) addr_n[0]   = 1'b0;
    if (size_n == 2'b10) addr_n[1:0] = 2'b00;
  end
`endif

  always_comb begin
    case (size_n)
      2'b00:   wdata_rep = {4{ls_wdata[7:0]}};
      2'b01:   wdata_rep = {2{ls_wdata[15:0]}};
      default: wdata_rep = ls_wdata;
    endcase
  end

  assign accept = (state == S_IDLE) && ls_req && !trap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= 2'b00;
      wdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        addr_q  <= addr_n;
        we_q    <= ls_we;
        uns_q   <= ls_uns;
        size_q  <= size_n;
        wdata_q <= wdata_rep;
      end
    end
  end

  always_comb begin
    case (addr_q[1:0])
      2'b00:   byte_v = ahb.hrdata[7:0];
      2'b01:   byte_v = ahb.hrdata[15:8];
      2'b10:   byte_v = ahb.hrdata[23:16];
      default: byte_v = ahb.hrdata[31:24];
    endcase
    half_v = addr_q[1] ? ahb.hrdata[31:16] : ahb.hrdata[15:0];
    case (size_q)
      2'b00:   ld_ext = {{24{~uns_q & byte_v[7]}}, byte_v};
      2'b01:   ld_ext = {{16{~uns_q & half_v[15]}}, half_v};
      default: ld_ext = ahb.hrdata;
    endcase
  end

  always_comb begin
    state_nxt = state;
    d_hready  = 1'b1;
    ld_valid  = 1'b0;
    ld_data   = '0;
    bus_err   = 1'b0;
    misalign  = trap;
    htrans_c  = 2'b00;
    hwdata_c  = '0;
    case (state)
      S_IDLE: begin
        d_hready = ~ls_req | trap;
        if (accept) state_nxt = S_ADDR;
      end
      S_ADDR: begin
        htrans_c = 2'b10;
        d_hready = 1'b0;
        if (ahb.hready_in) state_nxt = S_DATA;
      end
      S_DATA: begin
        hwdata_c = we_q ? wdata_q : 32'h0;
        d_hready = ahb.hready_in;
        // an ERROR with hready low is just the first half of the two-cycle response
        if (ahb.hready_in) begin
          state_nxt = S_IDLE;
          if (ahb.hresp) begin
            bus_err = 1'b1;
          end else if (!we_q) begin
            ld_valid = 1'b1;
            ld_data  = ld_ext;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign ahb.haddr  = addr_q;
  assign ahb.htrans = htrans_c;
  assign ahb.hwrite = we_q;
  assign ahb.hsize  = {1'b0, size_q};
  assign ahb.hburst = 3'b000;
  assign ahb.hprot  = HPROT_VAL;
  assign ahb.hwdata = hwdata_c;

endmodule

// File: tb/tb_lsu_ahb_dmaster.sv
// Scoreboard bench for lsu_ahb_dmaster: stimulus/slave task pushes expectations, negedge monitor checks.
module tb_lsu_ahb_dmaster;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ls_req, ls_we, ls_uns;
  logic [1:0]  ls_size;
  logic [31:0] ls_addr, ls_wdata;
  logic        d_hready, ld_valid, bus_err, misalign;
  logic [31:0] ld_data;

  lsu_ahb_dmaster_if #(.AW(32)) ahb ();

  lsu_ahb_dmaster #(.AW(32), .HPROT_VAL(4'b0001)) dut (
    .clk(clk), .rst_n(rst_n),
    .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size), .ls_uns(ls_uns),
    .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .d_hready(d_hready), .ld_data(ld_data), .ld_valid(ld_valid),
    .bus_err(bus_err), .misalign(misalign),
    .ahb(ahb)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [2:0]  size;
    logic [31:0] wdata;
  } bus_exp_t;

  typedef struct {
    logic        err;
    logic [31:0] data;
  } resp_exp_t;

  bus_exp_t  aq[$];
  bus_exp_t  dq[$];
  resp_exp_t rq[$];
  int        sq[$];

  int n_checks = 0;
  int n_fails  = 0;
  bit mon_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: pick the addressed lane by shifting, then extend arithmetically.
  function automatic logic [31:0] exp_load(input int eff, input bit uns,
                                           input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] v;
    if (eff == 0) begin
      v = (rd >> (8 * (a % 4))) & 32'hFF;
      if (!uns && v >= 32'd128) v = v - 32'd256;
    end else if (eff == 1) begin
      v = (rd >> (16 * ((a / 2) % 2))) & 32'hFFFF;
      if (!uns && v >= 32'd32768) v = v - 32'd65536;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  // Issues one request, acts as the bus slave, and records what the DUT must show.
  task automatic do_txn(input bit we, input int sz, input bit uns, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rdata,
                        input int aw, input int dw, input bit err);
    int          eff, nbytes, acnt, dcnt;
    bit          in_dp, ef, done;
    logic [31:0] rep;
    bus_exp_t    be;
    resp_exp_t   re;
    eff    = (sz == 3) ? 2 : sz;
    nbytes = 1 << eff;
    if (eff == 0)      rep = (wdata & 32'hFF) * 32'h0101_0101;
    else if (eff == 1) rep = (wdata & 32'hFFFF) * 32'h0001_0001;
    else               rep = wdata;
    be.addr  = addr - (addr % nbytes);
    be.we    = we;
    be.size  = 3'(eff);
    be.wdata = we ? rep : 32'h0;
    aq.push_back(be);
    dq.push_back(be);
    if (!we || err) begin
      re.err  = err;
      re.data = err ? 32'h0 : exp_load(eff, uns, addr, rdata);
      rq.push_back(re);
    end
    sq.push_back(2 + aw + dw + (err ? 1 : 0));

    @(posedge clk); #1;
    ls_req = 1'b1; ls_we = we; ls_size = 2'(sz); ls_uns = uns;
    ls_addr = addr; ls_wdata = wdata;
    ahb.hready_in = 1'b1; ahb.hresp = 1'b0; ahb.hrdata = $urandom;
    acnt = 0; dcnt = 0; in_dp = 0; ef = 0; done = 0;
    for (int cyc = 0; cyc < 64 && !done; cyc++) begin
      @(posedge clk); #1;
      if (!in_dp) begin
        ahb.hresp  = 1'b0;
        ahb.hrdata = $urandom;
        if (acnt < aw) ahb.hready_in = 1'b0;
        else begin ahb.hready_in = 1'b1; in_dp = 1; end
        acnt++;
      end else begin
        if (dcnt < dw) begin
          ahb.hready_in = 1'b0; ahb.hresp = 1'b0; ahb.hrdata = $urandom;
        end else if (err && !ef) begin
          ahb.hready_in = 1'b0; ahb.hresp = 1'b1; ef = 1;
        end else begin
          ahb.hready_in = 1'b1; ahb.hresp = err;
          ahb.hrdata = err ? $urandom : rdata;
          done = 1;
        end
        dcnt++;
      end
    end
    @(posedge clk); #1;
    ls_req = 1'b0; ahb.hready_in = 1'b1; ahb.hresp = 1'b0;
  endtask

  int       stall_cnt = 0;
  bit       in_data   = 0;
  bus_exp_t me;

  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (ld_valid || bus_err) begin
        if (rq.size() == 0) chk("unexpected_resp", {30'h0, bus_err, ld_valid}, 32'h0);
        else begin
          chk("resp_bus_err", {31'h0, bus_err}, {31'h0, rq[0].err});
          chk("resp_ld_valid", {31'h0, ld_valid}, {31'h0, ~rq[0].err});
          chk("resp_ld_data", ld_data, rq[0].data);
          void'(rq.pop_front());
        end
      end
      if (!d_hready) stall_cnt++;
      else if (stall_cnt > 0) begin
        if (sq.size() == 0) chk("unexpected_stall", stall_cnt, 0);
        else chk("stall_cycles", stall_cnt, sq.pop_front());
        stall_cnt = 0;
      end
      if (in_data) begin
        if (dq.size() == 0) chk("unexpected_data_phase", 1, 0);
        else begin
          me = dq[0];
          chk("htrans_data", {30'h0, ahb.htrans}, 32'h0);
          chk("hwdata", ahb.hwdata, me.wdata);
          if (ahb.hready_in) begin void'(dq.pop_front()); in_data = 0; end
        end
      end else if (ahb.htrans == 2'b10) begin
        if (aq.size() == 0) chk("unexpected_nonseq", 1, 0);
        else begin
          me = aq[0];
          chk("haddr", ahb.haddr, me.addr);
          chk("hwrite", {31'h0, ahb.hwrite}, {31'h0, me.we});
          chk("hsize", {29'h0, ahb.hsize}, {29'h0, me.size});
          chk("hburst", {29'h0, ahb.hburst}, 32'h0);
          chk("hprot", {28'h0, ahb.hprot}, 32'h1);
          if (ahb.hready_in) begin void'(aq.pop_front()); in_data = 1; end
        end
      end
`ifndef LSU_MISALIGN_TRAP_EN
      chk("misalign_tied", {31'h0, misalign}, 32'h0);
`endif
    end else begin
      stall_cnt = 0;
      in_data   = 0;
    end
  end

  task automatic chk_reset_state(input string tag);
    chk({tag, "_htrans"}, {30'h0, ahb.htrans}, 32'h0);
    chk({tag, "_haddr"}, ahb.haddr, 32'h0);
    chk({tag, "_hwdata"}, ahb.hwdata, 32'h0);
    chk({tag, "_hsize"}, {29'h0, ahb.hsize}, 32'h0);
    chk({tag, "_hwrite"}, {31'h0, ahb.hwrite}, 32'h0);
    chk({tag, "_d_hready"}, {31'h0, d_hready}, 32'h1);
    chk({tag, "_ld_valid"}, {31'h0, ld_valid}, 32'h0);
    chk({tag, "_bus_err"}, {31'h0, bus_err}, 32'h0);
    chk({tag, "_misalign"}, {31'h0, misalign}, 32'h0);
  endtask

  initial begin
    int          sz, off, aw, dw;
    bit          we, uns, err;
    logic [31:0] a;
    rst_n = 1'b0;
    ls_req = 1'b0; ls_we = 1'b0; ls_size = 2'b00; ls_uns = 1'b0;
    ls_addr = '0; ls_wdata = '0;
    ahb.hready_in = 1'b1; ahb.hresp = 1'b0; ahb.hrdata = '0;
    #12;
    chk_reset_state("rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    mon_en = 1'b1;
    #1 chk_reset_state("post_rst");

    do_txn(0, 2, 0, 32'h2000_0004, 32'h0, 32'h8899_AABB, 0, 0, 0);  // LW zero wait
    do_txn(0, 0, 0, 32'h2000_0003, 32'h0, 32'h80FF_0000, 0, 0, 0);  // LB
    do_txn(0, 0, 1, 32'h2000_0003, 32'h0, 32'h80FF_0000, 0, 0, 0);  // LBU
    do_txn(1, 1, 0, 32'h2000_0002, 32'h1234_ABCD, 32'h0, 0, 0, 0);  // SH
    do_txn(0, 2, 0, 32'h2000_0008, 32'h0, 32'hCAFE_F00D, 0, 3, 0);  // LW, 3 data waits
    do_txn(0, 2, 0, 32'h2000_000C, 32'h0, 32'h1111_2222, 0, 0, 1);  // LW error
    do_txn(1, 0, 0, 32'h2000_0011, 32'hA5A5_A55A, 32'h0, 1, 1, 1);  // SB error with waits
    do_txn(0, 3, 0, 32'h2000_0010, 32'h0, 32'h7654_3210, 0, 0, 0);  // size 11 as word

    // Reset while the address phase is on the bus
    mon_en = 1'b0;
    @(posedge clk); #1;
    ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'b10; ls_addr = 32'h2000_0020;
    @(posedge clk); #1;
    chk("t6_in_addr_phase", {30'h0, ahb.htrans}, 32'h2);
    ls_req = 1'b0;
    rst_n  = 1'b0;
    #1 chk("t6_htrans_async", {30'h0, ahb.htrans}, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    aq.delete(); dq.delete(); rq.delete(); sq.delete();
    @(posedge clk); #1;
    mon_en = 1'b1;
    do_txn(0, 2, 0, 32'h2000_0024, 32'h0, 32'hDEAD_BEEF, 0, 0, 0);

`ifdef LSU_MISALIGN_TRAP_EN
    @(posedge clk); #1;
    ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'b10; ls_uns = 1'b0; ls_addr = 32'h2000_0002;
    #1;
    chk("trap_misalign", {31'h0, misalign}, 32'h1);
    chk("trap_d_hready", {31'h0, d_hready}, 32'h1);
    chk("trap_ld_valid", {31'h0, ld_valid}, 32'h0);
    @(posedge clk); #1;
    ls_req = 1'b0;
    chk("trap_htrans_idle", {30'h0, ahb.htrans}, 32'h0);
    @(posedge clk); #1;
    ls_req = 1'b1; ls_size = 2'b01; ls_addr = 32'h2000_0005;
    #1 chk("trap_half", {31'h0, misalign}, 32'h1);
    @(posedge clk); #1;
    ls_req = 1'b0;
    chk("trap_half_htrans", {30'h0, ahb.htrans}, 32'h0);
`endif

    for (int n = 0; n < 150; n++) begin
      we  = 1'($urandom % 2);
      uns = 1'($urandom % 2);
      sz  = int'($urandom % 4);
      off = int'($urandom % 4);
`ifdef LSU_MISALIGN_TRAP_EN
      if (sz == 1) off = off & 2;
      if (sz >= 2) off = 0;
`endif
      a   = 32'h2000_0000 | ($urandom & 32'h0000_FFFC) | 32'(off);
      aw  = ($urandom % 4 == 0) ? 1 : 0;
      dw  = int'($urandom % 4);
      err = ($urandom % 8 == 0);
      do_txn(we, sz, uns, a, $urandom, $urandom, aw, dw, err);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("drain_addr_q", aq.size(), 0);
    chk("drain_data_q", dq.size(), 0);
    chk("drain_resp_q", rq.size(), 0);
    chk("drain_stall_q", sq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
